line_capture: RTL

//  Upstream stage of the conv/max peak finder. Assembles a serial camera pixel

---
 rtl/plazer_pkg.sv | 16 +
 rtl/sat_counter.sv | 24 ++
 rtl/line_capture.sv | 119 +++++++++++
 3 files changed

// File: rtl/plazer_pkg.sv
// Shared types for the plazer peak-finder pipeline (line_capture, convmax).
// Holds the line geometry, the pixel and line types, and the fill-state encoding.
package plazer_pkg;

    localparam int NPIX = 120;
    localparam int PIXW = 8;

    typedef logic [PIXW-1:0] pixel_t;
    typedef pixel_t [NPIX-1:0] line_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// Ports:
//   clk    clock
//   reset  async reset, clears count
//   inc    add one this cycle; ignored once count is all-ones
//   count  current value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/line_capture.sv
// Assembles a serial pixel stream into one NPIX-pixel scan line and presents it
// on a parallel bus with a valid/ack handshake. The next line fills in wbuf while
// the previous line is held in line_data. Completed lines that find the output
// occupied are dropped and counted; lines restarted by an early pix_sol are
// counted as short.
// Ports:
//   clk, reset                    clock, async active-high reset
//   pix_data/pix_valid/pix_sol    serial pixel input, pix_sol marks pixel 0
//   line_data/line_valid/line_ack parallel line output and handshake
//   line_id                       lines delivered, wraps
//   drop_count, short_count       saturating status counters
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a beat with pix_sol; other beats are discarded
// FILL  | pixels 1..NPIX-1 being written; wpos is the next index
module line_capture
    import plazer_pkg::*;
#(
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  pixel_t          pix_data,
    input  logic            pix_valid,
    input  logic            pix_sol,
    output line_t           line_data,
    output logic            line_valid,
    input  logic            line_ack,
    output logic [CNTW-1:0] line_id,
    output logic [CNTW-1:0] drop_count,
    output logic [CNTW-1:0] short_count
);

    localparam int WPW = $clog2(NPIX);
    localparam logic [WPW-1:0] LAST = WPW'(NPIX - 1);

    fill_state_t     state;
    logic [WPW-1:0]  wpos;
    // The final pixel goes straight from pix_data into line_data, so wbuf
    // only needs to hold pixels 0..NPIX-2.
    pixel_t [NPIX-2:0] wbuf;

    logic complete;
    logic load_ok;
    logic drop_inc;
    logic short_inc;

    always_comb begin
        complete  = pix_valid && (state == FILL) && !pix_sol && (wpos == LAST);
        load_ok   = !line_valid || line_ack;
        drop_inc  = complete && !load_ok;
        short_inc = pix_valid && (state == FILL) && pix_sol;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wpos       <= '0;
            wbuf       <= '0;
            line_data  <= '0;
            line_valid <= 1'b0;
            line_id    <= '0;
        end else begin
            if (line_ack && line_valid) begin
                line_valid <= 1'b0;
            end
            // A load on the same edge as an ack wins, keeping line_valid high.
            if (complete && load_ok) begin
                line_data  <= {pix_data, wbuf};
                line_valid <= 1'b1;
                line_id    <= line_id + CNTW'(1);
            end

            if (pix_valid) begin
                case (state)
                    IDLE: begin
                        if (pix_sol) begin
                            wbuf[0] <= pix_data;
                            wpos    <= WPW'(1);
                            state   <= FILL;
                        end
                    end
                    FILL: begin
                        if (pix_sol) begin
                            wbuf[0] <= pix_data;
                            wpos    <= WPW'(1);
                        end else if (wpos == LAST) begin
                            wpos  <= '0;
                            state <= IDLE;
                        end else begin
                            wbuf[wpos] <= pix_data;
                            wpos       <= wpos + WPW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        wpos  <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(CNTW)) u_drop_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (drop_inc),
        .count (drop_count)
    );

    sat_counter #(.W(CNTW)) u_short_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (short_inc),
        .count (short_count)
    );

endmodule
